// File: rtl/tc_result_drain.sv
// ============================================================================
// tc_result_drain
// ----------------------------------------------------------------------------
// Receive end of the tc_array datapath. Partial-sum beats of TILE_M lanes are
// accumulated lane by lane across a K-reduction packet (closed by in_last).
// Each finished result vector is pushed into a small FIFO and handed to the
// writeback path over a valid/ready interface.
//
// Optional feature (compile-time macro TC_DRAIN_SAT_EN):
//   defined   - lane sums that exceed 2^DW_ACC-1 clamp to all ones, and
//               sat_flag becomes a sticky indicator (cleared only by reset)
//   undefined - lane sums wrap modulo 2^DW_ACC, sat_flag is tied to 0
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous reset, active-high
//   in_valid    in   in_data / in_last valid
//   in_ready    out  block accepts a beat (low while reset or FIFO full)
//   in_data     in   TILE_M*DW_DATA, lane i at [i*DW_DATA +: DW_DATA]
//   in_last     in   beat closes the current packet
//   out_valid   out  FIFO head valid
//   out_ready   in   consumer takes the head
//   out_data    out  TILE_M*DW_ACC, lane i at [i*DW_ACC +: DW_ACC]; 0 when idle
//   fifo_level  out  number of stored results
//   sat_flag    out  sticky saturation indicator
// ============================================================================
module tc_result_drain #(
    parameter int TILE_M     = 4,
    parameter int DW_DATA    = 8,
    parameter int DW_ACC     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [TILE_M*DW_DATA-1:0]        in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TILE_M*DW_ACC-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             sat_flag
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int VW = TILE_M * DW_ACC;

    // Accumulator state
    logic [VW-1:0]  acc_reg;
    logic [VW-1:0]  acc_next;
    logic           first_reg;
    logic           first_next;
    logic [VW-1:0]  sum_vec;

    // Result FIFO state
    logic [VW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [LW-1:0]  level_reg;
    logic [LW-1:0]  level_next;

    logic           accept;
    logic           push;
    logic           pop;

    // ------------------------------------------------------------------------
    // Handshakes. in_ready deliberately ignores a same-cycle pop so that the
    // ready path does not depend on out_ready.
    // ------------------------------------------------------------------------
    assign in_ready   = !reset && (level_reg != LW'(FIFO_DEPTH));
    assign accept     = in_valid && in_ready;
    assign push       = accept && in_last;
    assign out_valid  = (level_reg != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign fifo_level = level_reg;

    // ------------------------------------------------------------------------
    // Per-lane adders. On the first beat of a packet the stored accumulator is
    // ignored, so a packet never inherits stale partial sums.
    // ------------------------------------------------------------------------
`ifdef TC_DRAIN_SAT_EN
    logic [TILE_M-1:0] lane_clamp;
`endif

    generate
        for (genvar gi = 0; gi < TILE_M; gi++) begin : g_lane
            logic [DW_ACC-1:0] base;
            logic [DW_ACC-1:0] addend;

            assign base   = first_reg ? '0 : acc_reg[gi*DW_ACC +: DW_ACC];
            assign addend = DW_ACC'(in_data[gi*DW_DATA +: DW_DATA]);

`ifdef TC_DRAIN_SAT_EN
            // One extra bit catches the carry-out; a clamped lane that keeps
            // receiving data overflows again and therefore stays clamped.
            logic [DW_ACC:0] wide;
            assign wide                        = {1'b0, base} + {1'b0, addend};
            assign lane_clamp[gi]              = wide[DW_ACC];
            assign sum_vec[gi*DW_ACC +: DW_ACC] = wide[DW_ACC] ? '1 : wide[DW_ACC-1:0];
`else
            assign sum_vec[gi*DW_ACC +: DW_ACC] = base + addend;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        acc_next   = acc_reg;
        first_next = first_reg;
        if (accept) begin
            if (in_last) begin
                acc_next   = '0;
                first_next = 1'b1;
            end else begin
                acc_next   = sum_vec;
                first_next = 1'b0;
            end
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg    <= '0;
            first_reg  <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            acc_reg    <= acc_next;
            first_reg  <= first_next;
            level_reg  <= level_next;
            // FIFO_DEPTH is a power of two, so natural overflow wraps.
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: out_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= sum_vec;
    end

`ifdef TC_DRAIN_SAT_EN
    logic sat_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_reg <= 1'b0;
        end else if (accept && (|lane_clamp)) begin
            sat_reg <= 1'b1;
        end
    end

    assign sat_flag = sat_reg;
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_tc_result_drain.sv
// ============================================================================
// tb_tc_result_drain
// Directed self-checking bench for tc_result_drain with TILE_M=4, DW_DATA=8,
// DW_ACC=16, FIFO_DEPTH=4. Inputs are driven 1 ns after a rising edge and
// outputs are sampled at the same point, away from the active edge.
// ============================================================================
module tb_tc_result_drain;

    localparam int TILE_M     = 4;
    localparam int DW_DATA    = 8;
    localparam int DW_ACC     = 16;
    localparam int FIFO_DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [TILE_M*DW_DATA-1:0] in_data = '0;
    logic                      in_last = 1'b0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic [TILE_M*DW_ACC-1:0]  out_data;
    logic [2:0]                fifo_level;
    logic                      sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    tc_result_drain #(
        .TILE_M     (TILE_M),
        .DW_DATA    (DW_DATA),
        .DW_ACC     (DW_ACC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [31:0] rep8(input logic [7:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [63:0] rep16(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [31:0] d, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check_val("send_timeout_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp5;
        logic        exp_sat;
        bit          took;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_in_ready",   64'(in_ready),   64'd0);
        check_val("rst_out_valid",  64'(out_valid),  64'd0);
        check_val("rst_out_data",   out_data,        64'd0);
        check_val("rst_fifo_level", 64'(fifo_level), 64'd0);
        check_val("rst_sat_flag",   64'(sat_flag),   64'd0);
        reset = 1'b0;
        #1;
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // ---------------- test 1: single beat ----------------
        out_ready = 1'b1;
        send_beat(32'h04030201, 1'b1);
        check_val("t1_out_valid", 64'(out_valid), 64'd1);
        check_val("t1_out_data",  out_data, 64'h0004_0003_0002_0001);
        tick();
        check_val("t1_out_valid_one_cycle", 64'(out_valid), 64'd0);

        // ---------------- test 2: multi-beat ----------------
        for (int i = 0; i < 8; i++) begin
            send_beat(32'hFFFF_FFFF, (i == 7));
            if (i < 7) check_val("t2_no_early_out", 64'(out_valid), 64'd0);
        end
        check_val("t2_out_valid", 64'(out_valid), 64'd1);
        check_val("t2_out_data",  out_data, rep16(16'd2040));
        tick();

        // ---------------- test 3: backpressure ----------------
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) send_beat(rep8(8'(v)), 1'b1);
        check_val("t3_level_full", 64'(fifo_level), 64'd4);
        check_val("t3_in_ready_full", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = rep8(8'd5);
        in_last  = 1'b1;
        tick();
        tick();
        check_val("t3_fifth_held_level", 64'(fifo_level), 64'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("t3_drain_valid", 64'(out_valid), 64'd1);
            check_val("t3_drain_data",  out_data, rep16(16'(i + 1)));
            took = in_valid && in_ready;
            tick();
            if (took) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end
        check_val("t3_empty", 64'(out_valid), 64'd0);
        check_val("t3_fifth_taken", 64'(in_valid), 64'd0);

        // ---------------- test 4: push and pop in one cycle ----------------
        out_ready = 1'b0;
        send_beat(rep8(8'd6), 1'b1);
        send_beat(rep8(8'd7), 1'b1);
        check_val("t4_level2", 64'(fifo_level), 64'd2);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rep8(8'd8);
        in_last   = 1'b1;
        check_val("t4_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_val("t4_level_kept", 64'(fifo_level), 64'd2);
        check_val("t4_head7", out_data, rep16(16'd7));
        tick();
        check_val("t4_head8", out_data, rep16(16'd8));
        check_val("t4_level1", 64'(fifo_level), 64'd1);
        tick();
        check_val("t4_empty", 64'(out_valid), 64'd0);

        // ---------------- test 5: overflow ----------------
`ifdef TC_DRAIN_SAT_EN
        exp5    = rep16(16'd65535);
        exp_sat = 1'b1;
`else
        exp5    = rep16(16'd10964);
        exp_sat = 1'b0;
`endif
        check_val("t5_sat_before", 64'(sat_flag), 64'd0);
        for (int i = 0; i < 300; i++) send_beat(32'hFFFF_FFFF, (i == 299));
        check_val("t5_out_data", out_data, exp5);
        check_val("t5_sat_flag", 64'(sat_flag), 64'(exp_sat));
        tick();

        // ---------------- test 6: reset mid-packet ----------------
        out_ready = 1'b0;
        send_beat(rep8(8'd9), 1'b1);
        for (int i = 0; i < 3; i++) send_beat(rep8(8'd1), 1'b0);
        check_val("t6_level_before", 64'(fifo_level), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_async_out_valid",  64'(out_valid),  64'd0);
        check_val("t6_async_out_data",   out_data,        64'd0);
        check_val("t6_async_fifo_level", 64'(fifo_level), 64'd0);
        check_val("t6_async_in_ready",   64'(in_ready),   64'd0);
        check_val("t6_async_sat_flag",   64'(sat_flag),   64'd0);
        #2;
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        send_beat(rep8(8'd5), 1'b1);
        check_val("t6_new_packet", out_data, rep16(16'd5));
        check_val("t6_level1", 64'(fifo_level), 64'd1);
        tick();
        check_val("t6_empty", 64'(fifo_level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
